// File: rtl/booth_pkg.sv
// booth_pkg: shared defaults, state type and sign-extension helper for the Booth accumulate stage.
// The saturating build (BOOTH_ACC_SAT_EN) only affects booth_acc_add.
package booth_pkg;
  localparam int N_DEF = 8;
  localparam int GUARD_DEF = 4;
  localparam int LEN_DEF = 8;
  localparam int MAX_W = 64;
  typedef enum logic {ACC, HOLD} acc_state_t;
  // Sign-extends the low pw bits of p across the full MAX_W-bit word; callers truncate to ACC_W.
  function automatic logic [MAX_W-1:0] sext(input logic [MAX_W-1:0] p, input int unsigned pw);
    logic signed [MAX_W-1:0] t;
    t = p << (MAX_W - pw);
    return t >>> (MAX_W - pw);
  endfunction
endpackage

// File: rtl/booth_mac_acc_add.sv
// booth_acc_add: ACC_W-bit signed adder with overflow flag.
// With BOOTH_ACC_SAT_EN defined the sum clamps to the signed range on overflow; otherwise it wraps.
module booth_acc_add #(
  parameter int ACC_W = 21
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);
  logic [ACC_W-1:0] raw;
  always_comb begin
    raw = a + b;
    ovf = (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);
`ifdef BOOTH_ACC_SAT_EN
    sum = ovf ? {a[ACC_W-1], {(ACC_W-1){~a[ACC_W-1]}}} : raw;
`else
    sum = raw;
`endif
  end
endmodule

// File: rtl/booth_mac_acc.sv
// booth_mac_acc: frame accumulator for signed Booth products with valid/ready in and out.
// Define BOOTH_ACC_SAT_EN to make the accumulator saturate instead of wrap.
module booth_mac_acc
  import booth_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int GUARD = GUARD_DEF,
  parameter int ACC_W = 2*N+1+GUARD,
  parameter int LEN   = LEN_DEF,
  parameter int CNT_W = $clog2(LEN+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*N:0]     in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);
  localparam int P_W = 2*N+1;
  acc_state_t state, state_next;
  logic [ACC_W-1:0] acc, prod_ext, sum;
  logic [CNT_W-1:0] count, count_next;
  logic sticky, ovf, accept, close;
  assign prod_ext = ACC_W'(sext(MAX_W'(in_prod), P_W));
  booth_acc_add #(.ACC_W(ACC_W)) u_add (
    .a  (acc),
    .b  (prod_ext),
    .sum(sum),
    .ovf(ovf)
  );
  // A beat coincident with clear is treated as consumed but never summed.
  always_comb begin
    in_ready   = state == ACC;
    out_valid  = state == HOLD;
    accept     = in_valid && in_ready && !clear;
    count_next = count + CNT_W'(1);
    close      = accept && (in_last || count_next == CNT_W'(LEN));
    state_next = clear ? ACC : (state == HOLD) ? (out_ready ? ACC : HOLD) : (close ? HOLD : ACC);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACC;
      acc       <= '0;
      count     <= '0;
      sticky    <= 1'b0;
      out_acc   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      state <= state_next;
      if (clear || (state == HOLD && out_ready)) begin
        acc    <= '0;
        count  <= '0;
        sticky <= 1'b0;
      end else if (accept) begin
        acc    <= sum;
        count  <= count_next;
        sticky <= sticky | ovf;
      end
      if (close) begin
        out_acc   <= sum;
        out_count <= count_next;
        out_ovf   <= sticky | ovf;
      end
    end
  end
endmodule

// File: tb/tb_booth_mac_acc.sv
// tb_booth_mac_acc: randomized and directed checks of booth_mac_acc against a behavioural frame model.
// Expected saturation results follow BOOTH_ACC_SAT_EN.
module tb_booth_mac_acc;
  localparam int N = 8;
  localparam int GUARD = 4;
  localparam int LEN = 8;
  localparam int ACC_W = 2*N+1+GUARD;
  localparam int CNT_W = $clog2(LEN+1);
  localparam int ACC_W2 = 2*N+2;
`ifdef BOOTH_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [2*N:0] in_prod = '0;
  logic in_ready, out_valid, out_ovf, in_ready2, out_valid2, out_ovf2;
  logic [ACC_W-1:0] out_acc;
  logic [ACC_W2-1:0] out_acc2;
  logic [CNT_W-1:0] out_count, out_count2;
  booth_mac_acc #(.N(N), .GUARD(GUARD), .LEN(LEN)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_count(out_count), .out_ovf(out_ovf)
  );
  booth_mac_acc #(.N(N), .GUARD(1), .LEN(LEN)) dut2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready2),
    .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid2), .out_ready(out_ready),
    .out_acc(out_acc2), .out_count(out_count2), .out_ovf(out_ovf2)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic bit add_ovf(input longint a, input longint p, input int w);
    longint s = a + p;
    longint lim = longint'(1) << (w-1);
    return (s > lim - 1) || (s < -lim);
  endfunction
  function automatic longint add_res(input longint a, input longint p, input int w, input bit sat);
    longint s = a + p;
    longint lim = longint'(1) << (w-1);
    if (s > lim - 1) return sat ? lim - 1 : s - 2*lim;
    if (s < -lim) return sat ? -lim : s + 2*lim;
    return s;
  endfunction
  // Frame model: running true-integer sum, term count, pending-result flag.
  logic m_hold;
  longint m_acc, e_acc, p_now;
  int m_cnt, e_cnt;
  bit m_sticky, e_ovf;
  assign p_now = longint'($signed(in_prod));
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hold <= 1'b0; m_acc <= 0; m_cnt <= 0; m_sticky <= 1'b0;
      e_acc <= 0; e_cnt <= 0; e_ovf <= 1'b0;
    end else if (clear || (m_hold && out_ready)) begin
      m_hold <= 1'b0; m_acc <= 0; m_cnt <= 0; m_sticky <= 1'b0;
    end else if (!m_hold && in_valid) begin
      m_acc <= add_res(m_acc, p_now, ACC_W, SAT);
      m_cnt <= m_cnt + 1;
      m_sticky <= m_sticky | add_ovf(m_acc, p_now, ACC_W);
      if (in_last || m_cnt + 1 == LEN) begin
        m_hold <= 1'b1;
        e_acc <= add_res(m_acc, p_now, ACC_W, SAT);
        e_cnt <= m_cnt + 1;
        e_ovf <= m_sticky | add_ovf(m_acc, p_now, ACC_W);
      end
    end
  end
  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_in_ready", in_ready, !m_hold);
      chk("model_out_valid", out_valid, m_hold);
      if (m_hold) begin
        chk("model_out_acc", $signed(out_acc), e_acc);
        chk("model_out_count", out_count, e_cnt);
        chk("model_out_ovf", out_ovf, e_ovf);
      end
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input logic signed [2*N:0] p, input logic last);
    in_valid = 1'b1; in_prod = p; in_last = last;
    cyc();
    in_valid = 1'b0; in_last = 1'b0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_acc", out_acc, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_ovf", out_ovf, 0);
    out_ready = 1'b1;
    beat(100, 0); beat(-30, 0); beat(7, 0); beat(1, 1);
    chk("f1_valid", out_valid, 1);
    chk("f1_acc", $signed(out_acc), 78);
    chk("f1_count", out_count, 4);
    chk("f1_ovf", out_ovf, 0);
    cyc();
    chk("f1_valid_drop", out_valid, 0);
    out_ready = 1'b0;
    repeat (8) beat(1, 0);
    chk("len_valid", out_valid, 1);
    chk("len_in_ready", in_ready, 0);
    chk("len_acc", $signed(out_acc), 8);
    chk("len_count", out_count, 8);
    in_valid = 1'b1; in_prod = 1;
    repeat (5) begin
      cyc();
      chk("hold_valid", out_valid, 1);
      chk("hold_acc", $signed(out_acc), 8);
      chk("hold_count", out_count, 8);
    end
    out_ready = 1'b1;
    cyc();
    chk("handoff_valid", out_valid, 0);
    in_valid = 1'b0;
    beat(1, 0); beat(1, 1);
    chk("f3_acc", $signed(out_acc), 2);
    chk("f3_count", out_count, 2);
    cyc();
    beat(9, 0); beat(9, 0); beat(9, 0);
    clear = 1'b1; in_valid = 1'b1; in_prod = 50;
    cyc();
    clear = 1'b0; in_valid = 1'b0;
    beat(5, 0); beat(5, 1);
    chk("clr_acc", $signed(out_acc), 10);
    chk("clr_count", out_count, 2);
    cyc();
    beat(65535, 0); beat(65535, 0); beat(65535, 1);
    chk("g1_acc", $signed(out_acc2), SAT ? 131071 : -65539);
    chk("g1_ovf", out_ovf2, 1);
    chk("g4_acc", $signed(out_acc), 196605);
    chk("g4_ovf", out_ovf, 0);
    cyc();
    out_ready = 1'b0;
    beat(3, 1);
    chk("ar_valid_before", out_valid, 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", out_valid, 0);
    chk("ar_out_acc", out_acc, 0);
    chk("ar_out_count", out_count, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    chk("ar_in_ready", in_ready, 1);
    repeat (600) begin
      in_valid = 1'($urandom_range(0, 1));
      in_prod = 17'($urandom);
      in_last = ($urandom_range(0, 3) == 0);
      out_ready = 1'($urandom_range(0, 1));
      clear = ($urandom_range(0, 29) == 0);
      cyc();
    end
    in_valid = 1'b0; clear = 1'b0; in_last = 1'b0;
    repeat (2) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
